// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a write-to-read bypass,
// a dedicated link-register write port and a sequential clear engine.
// Reads are registered (one edge of latency). After reset or a clear
// request the file walks every entry to zero before Ready rises.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int LINK_REG = 31
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
  output logic [NUM_RD*DATA_W-1:0]   RdData,
  input  logic                       WrEn,
  input  logic [ADDR_W-1:0]          WrAddr,
  input  logic [DATA_W-1:0]          WrData,
  input  logic                       LinkEn,
  input  logic [DATA_W-1:0]          LinkData,
  input  logic                       ClearReq,
  output logic                       Ready
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [0:0]        ST_CLEAR = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;
  localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W:0]   IDX_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W+1)'(1);
  localparam bit                HAS_ZERO = (ZERO_REG != 0);

  logic [0:0]        state;
  logic [ADDR_W:0]   idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_next [NUM_RD];
  logic              run;
  logic              wr_ok;
  logic              link_ok;

  // A write is accepted only in RUN, not on a clear-request edge, and
  // never into entry 0 when that entry is hardwired to zero.
  assign run     = (state == ST_RUN);
  assign wr_ok   = run && WrEn && !ClearReq && !(HAS_ZERO && (WrAddr == '0));
  assign link_ok = run && LinkEn && !ClearReq && !(HAS_ZERO && (LINK_A == '0));

  // Clear engine sequencing and Ready; reset and clear requests restart at entry 0.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_CLEAR;
      idx   <= '0;
      Ready <= 1'b0;
    end else if (state == ST_CLEAR) begin
      idx <= idx + IDX_ONE;
      if (idx == IDX_LAST) begin
        state <= ST_RUN;
        Ready <= 1'b1;
      end
    end else if (ClearReq) begin
      state <= ST_CLEAR;
      idx   <= '0;
      Ready <= 1'b0;
    end
  end

  // Storage update: zero one entry per edge while clearing, otherwise
  // apply writeback and link writes with the link write taking priority.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (state == ST_CLEAR) begin
        mem[idx[ADDR_W-1:0]] <= '0;
      end else begin
        if (wr_ok && !(link_ok && (WrAddr == LINK_A)))
          mem[WrAddr] <= WrData;
        if (link_ok)
          mem[LINK_A] <= LinkData;
      end
    end
  end

  // Next read value per port: stored entry, overridden by same-edge writes
  // (link over writeback), and forced to zero for a hardwired entry 0.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_next[k] = mem[RdAddr[k*ADDR_W +: ADDR_W]];
      if (wr_ok && (WrAddr == RdAddr[k*ADDR_W +: ADDR_W]))
        rd_next[k] = WrData;
      if (link_ok && (LINK_A == RdAddr[k*ADDR_W +: ADDR_W]))
        rd_next[k] = LinkData;
      if (HAS_ZERO && (RdAddr[k*ADDR_W +: ADDR_W] == '0))
        rd_next[k] = '0;
    end
  end

  // Registered read ports; held at zero during reset, clearing and clear requests.
  always_ff @(posedge Clock) begin
    if (Reset || !run || ClearReq) begin
      RdData <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++)
        RdData[k*DATA_W +: DATA_W] <= rd_next[k];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp with default parameters
// and with a 4-port, 8-entry, 16-bit configuration without a zero register.
module tb_regfile_mp;

  logic Clock;

  // Default-parameter instance (32x32, 2 read ports, zero reg, link 31)
  logic        a_reset;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_link_en;
  logic [31:0] a_link_data;
  logic        a_clear;
  logic        a_ready;

  // Sweep instance (8x16, 4 read ports, no zero reg, link 7)
  logic        b_reset;
  logic [11:0] b_rd_addr;
  logic [63:0] b_rd_data;
  logic        b_wr_en;
  logic [2:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_link_en;
  logic [15:0] b_link_data;
  logic        b_clear;
  logic        b_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  regfile_mp dut_a (
    .Clock(Clock), .Reset(a_reset), .RdAddr(a_rd_addr), .RdData(a_rd_data),
    .WrEn(a_wr_en), .WrAddr(a_wr_addr), .WrData(a_wr_data),
    .LinkEn(a_link_en), .LinkData(a_link_data), .ClearReq(a_clear), .Ready(a_ready)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .LINK_REG(7)) dut_b (
    .Clock(Clock), .Reset(b_reset), .RdAddr(b_rd_addr), .RdData(b_rd_data),
    .WrEn(b_wr_en), .WrAddr(b_wr_addr), .WrData(b_wr_data),
    .LinkEn(b_link_en), .LinkData(b_link_data), .ClearReq(b_clear), .Ready(b_ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h0000DEAD;
    a_rd_addr = {5'd3, 5'd3};
    step();
    total_cnt++;
    if (a_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", a_ready);
    else pass_cnt++;
    total_cnt++;
    if (a_rd_data !== 64'h0) $display("[TB] FAIL reset_rddata: got %h expected 0", a_rd_data);
    else pass_cnt++;
    a_reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      total_cnt++;
      if (a_ready !== (i == 32)) $display("[TB] FAIL reset_ready_edge%0d: got %b expected %b", i, a_ready, (i == 32));
      else pass_cnt++;
      if (i == 10) begin
        total_cnt++;
        if (a_rd_data !== 64'h0) $display("[TB] FAIL clear_rddata_held: got %h expected 0", a_rd_data);
        else pass_cnt++;
      end
    end
    a_wr_en = 1'b0;
    step();
    total_cnt++;
    if (a_rd_data[31:0] !== 32'h0) $display("[TB] FAIL reset_entry3: got %h expected 0", a_rd_data[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_basic_rw();
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'h12345678; a_rd_addr = {5'd1, 5'd1};
    step();
    a_wr_addr = 5'd6; a_wr_data = 32'h80000001; a_rd_addr = {5'd1, 5'd5};
    step();
    total_cnt++;
    if (a_rd_data[31:0] !== 32'h12345678) $display("[TB] FAIL basic_read5: got %h expected 12345678", a_rd_data[31:0]);
    else pass_cnt++;
    a_wr_en = 1'b0; a_rd_addr = {5'd6, 5'd5};
    step();
    total_cnt++;
    if (a_rd_data !== {32'h80000001, 32'h12345678}) $display("[TB] FAIL basic_read56: got %h expected 8000000112345678", a_rd_data);
    else pass_cnt++;
  endtask

  task automatic test_bypass_zero();
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'hA5A5A5A5; a_rd_addr = {5'd0, 5'd7};
    step();
    total_cnt++;
    if (a_rd_data[31:0] !== 32'hA5A5A5A5) $display("[TB] FAIL bypass_port0: got %h expected a5a5a5a5", a_rd_data[31:0]);
    else pass_cnt++;
    total_cnt++;
    if (a_rd_data[63:32] !== 32'h0) $display("[TB] FAIL bypass_port1_zero: got %h expected 0", a_rd_data[63:32]);
    else pass_cnt++;
    a_wr_en = 1'b0; a_rd_addr = {5'd7, 5'd7};
    step();
    total_cnt++;
    if (a_rd_data !== {2{32'hA5A5A5A5}}) $display("[TB] FAIL same_addr_ports: got %h expected a5a5a5a5a5a5a5a5", a_rd_data);
    else pass_cnt++;
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF; a_rd_addr = {5'd0, 5'd0};
    step();
    total_cnt++;
    if (a_rd_data !== 64'h0) $display("[TB] FAIL zero_bypass: got %h expected 0", a_rd_data);
    else pass_cnt++;
    a_wr_en = 1'b0;
    step();
    total_cnt++;
    if (a_rd_data !== 64'h0) $display("[TB] FAIL zero_stored: got %h expected 0", a_rd_data);
    else pass_cnt++;
  endtask

  task automatic test_link_priority();
    a_wr_en = 1'b1; a_wr_addr = 5'd31; a_wr_data = 32'h00001111;
    a_link_en = 1'b1; a_link_data = 32'h00400020; a_rd_addr = {5'd31, 5'd7};
    step();
    total_cnt++;
    if (a_rd_data[63:32] !== 32'h00400020) $display("[TB] FAIL link_bypass: got %h expected 00400020", a_rd_data[63:32]);
    else pass_cnt++;
    a_wr_en = 1'b0; a_link_en = 1'b0; a_rd_addr = {5'd31, 5'd31};
    step();
    total_cnt++;
    if (a_rd_data !== {2{32'h00400020}}) $display("[TB] FAIL link_stored: got %h expected 0040002000400020", a_rd_data);
    else pass_cnt++;
    a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h00000044;
    a_link_en = 1'b1; a_link_data = 32'h00000088; a_rd_addr = {5'd31, 5'd4};
    step();
    total_cnt++;
    if (a_rd_data !== {32'h00000088, 32'h00000044}) $display("[TB] FAIL link_and_wb: got %h expected 0000008800000044", a_rd_data);
    else pass_cnt++;
    a_wr_en = 1'b0; a_link_en = 1'b0;
    step();
    total_cnt++;
    if (a_rd_data !== {32'h00000088, 32'h00000044}) $display("[TB] FAIL link_and_wb_stored: got %h expected 0000008800000044", a_rd_data);
    else pass_cnt++;
  endtask

  task automatic test_restart_mid_clear();
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h0000BEEF; a_rd_addr = {5'd1, 5'd1};
    step();
    a_wr_en = 1'b0; a_rd_addr = {5'd1, 5'd9};
    step();
    total_cnt++;
    if (a_rd_data[31:0] !== 32'h0000BEEF) $display("[TB] FAIL restart_pre_read9: got %h expected 0000beef", a_rd_data[31:0]);
    else pass_cnt++;
    a_clear = 1'b1; a_wr_en = 1'b1; a_wr_addr = 5'd10; a_wr_data = 32'h00001234;
    step();
    a_clear = 1'b0; a_wr_en = 1'b0;
    total_cnt++;
    if (a_ready !== 1'b0) $display("[TB] FAIL clearreq_ready: got %b expected 0", a_ready);
    else pass_cnt++;
    total_cnt++;
    if (a_rd_data !== 64'h0) $display("[TB] FAIL clearreq_rddata: got %h expected 0", a_rd_data);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) step();
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      total_cnt++;
      if (a_ready !== (i == 32)) $display("[TB] FAIL restart_ready_edge%0d: got %b expected %b", i, a_ready, (i == 32));
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (a_rd_data[31:0] !== 32'h0) $display("[TB] FAIL restart_entry9: got %h expected 0", a_rd_data[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_param_sweep();
    b_reset = 1'b1;
    step();
    b_reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      total_cnt++;
      if (b_ready !== (i == 8)) $display("[TB] FAIL sweep_ready_edge%0d: got %b expected %b", i, b_ready, (i == 8));
      else pass_cnt++;
    end
    b_wr_en = 1'b1; b_wr_addr = 3'd0; b_wr_data = 16'h7FFF; b_rd_addr = 12'h000;
    step();
    total_cnt++;
    if (b_rd_data !== {4{16'h7FFF}}) $display("[TB] FAIL sweep_bypass_entry0: got %h expected 7fff7fff7fff7fff", b_rd_data);
    else pass_cnt++;
    b_wr_en = 1'b0;
    step();
    total_cnt++;
    if (b_rd_data !== {4{16'h7FFF}}) $display("[TB] FAIL sweep_stored_entry0: got %h expected 7fff7fff7fff7fff", b_rd_data);
    else pass_cnt++;
  endtask

  // Test sequence
  initial begin
    a_reset = 1'b1; a_rd_addr = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    a_link_en = 1'b0; a_link_data = '0; a_clear = 1'b0;
    b_reset = 1'b1; b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_link_en = 1'b0; b_link_data = '0; b_clear = 1'b0;
    step();
    test_reset();
    test_basic_rw();
    test_bypass_zero();
    test_link_priority();
    test_restart_mid_clear();
    test_param_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
